sram_store_buffer: RTL and testbench
====================================

# sram_store_buffer

Posted-write buffer and request initiator placed between the CPU's MEM stage and the SRAM controller's rd_en/wr_en/ready handshake. Stores are accepted in one cycle into a small FIFO and drained to the controller in the background, so the pipeline freezes only when the buffer is full or a load must go to memory. Loads are ordered behind buffered stores, and are optionally served directly from the buffer on an address hit. The CPU drives its freeze from ~cpu_ready exactly as it does from the controller's ready today.

## Interface
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clock  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cpu_rd_en  input  1  load request, held until completion
- cpu_wr_en  input  1  store request, held until completion
- cpu_addr  input  ADDR_W  request address
- cpu_wdata  input  DATA_W  store data
- cpu_rdata  output  DATA_W  load data, valid when cpu_ready=1 on a load
- cpu_ready  output  1  request completes on this edge; 1 when no request
- mem_rd_en  output  1  read request to controller
- mem_wr_en  output  1  write request to controller
- mem_addr  output  ADDR_W  controller address
- mem_wdata  output  DATA_W  controller write data
- mem_rdata  input  DATA_W  controller read data, valid with mem_ready
- mem_ready  input  1  controller ready; access completes on edge where request=1 and mem_ready=1
- full, empty  output  1  FIFO status, registered
- count  output  $clog2(DEPTH)+1  occupancy, registered

## Operation
- FIFO of {addr, data}, circular head/tail pointers, count register; push and pop on the same edge leave count unchanged.
- Store: accepted iff count<DEPTH; cpu_ready=1 combinationally, push on that edge. Full: cpu_ready=0 until a pop frees an entry, accept on the following cycle.
- Drain FSM states IDLE, DRAIN, READ, RDONE.
  - IDLE: if a load is pending and needs memory and FIFO empty → READ; else if count>0 → DRAIN; else stay.
  - DRAIN: mem_wr_en=1, mem_addr/mem_wdata = head entry; on mem_ready=1 edge pop and → IDLE.
  - READ: mem_rd_en=1, mem_addr=cpu_addr; on mem_ready=1 edge latch mem_rdata → RDONE.
  - RDONE: cpu_ready=1, cpu_rdata=latched value; → IDLE.
- One IDLE cycle always separates consecutive controller accesses; mem_rd_en and mem_wr_en are never both 1.
- Load ordering: a load that needs memory waits until the FIFO is fully drained.
- Multiple stores to the same address are all kept and drained in program order.
- Reset values: count=0, empty=1, full=0, state IDLE, mem_rd_en=mem_wr_en=0, mem_addr=mem_wdata=0, cpu_rdata=0, cpu_ready=1 (no request).
- Reset mid-drain or mid-read: buffered stores are discarded, request lines drop asynchronously, FSM returns to IDLE.

## Timing
- Store, not full: 0 wait cycles (cpu_ready high in the request cycle).
- Store to controller: push at edge E, DRAIN entered at E+1, mem_wr_en high from E+1 until the mem_ready edge.
- Load miss, empty FIFO, controller needing L cycles with mem_ready=0: cpu_ready rises L+2 cycles after the request (1 IDLE→READ, L busy, 1 RDONE).
- Load behind k buffered stores: k full drains (each access plus 1 IDLE gap) before READ.
- cpu_ready, mem_rd_en, mem_wr_en: combinational from state, registered FIFO status, and cpu request inputs only; no path from mem_rdata.

## Configuration
- SRAM_STORE_FWD_EN defined: on a load, cpu_addr is compared against all valid entries. On a hit, cpu_ready=1 in the same cycle and cpu_rdata = data of the youngest matching entry, with no controller access. On a miss, normal drain-then-READ behaviour applies.
- SRAM_STORE_FWD_EN undefined: no comparators. Every load drains the FIFO and then performs READ.

## Test plan
- Reset: assert rst mid-sequence → cpu_ready=1, empty=1, count=0, mem_rd_en=mem_wr_en=0 immediately.
- Store 0x400←0xDEADBEEF, controller L=3 → cpu_ready=1 in the request cycle; count=1; mem_wr_en high for 4 cycles with mem_addr=0x400; then empty=1.
- Five back-to-back stores with mem_ready held 0 → full=1 after the 4th; 5th sees cpu_ready=0 until the first pop, then is accepted; drain order matches issue order.
- Stores 0x404←0x11 and 0x404←0x22, then load 0x404 → with macro: cpu_rdata=0x22 in the same cycle, no mem_rd_en; without macro: two drains, then READ returns 0x22.
- Load 0x500, FIFO empty, L=5 → mem_rd_en for 6 cycles, cpu_ready at cycle 7, cpu_rdata = the SRAM value.
- A store is accepted on the same edge the controller completes a pop while count=DEPTH-1 → count unchanged and pointers wrap correctly.

Source files
------------

// File: rtl/sram_store_buffer.sv
// Posted-write store buffer between the CPU MEM stage and the SRAM controller handshake.
// Optional store-to-load forwarding is enabled by defining SRAM_STORE_FWD_EN.
module sram_store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     cpu_rd_en,
   input  logic                     cpu_wr_en,
   input  logic [ADDR_W-1:0]        cpu_addr,
   input  logic [DATA_W-1:0]        cpu_wdata,
   output logic [DATA_W-1:0]        cpu_rdata,
   output logic                     cpu_ready,
   output logic                     mem_rd_en,
   output logic                     mem_wr_en,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ready,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, DRAIN, READ, RDONE} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_mem [DEPTH];
   logic [DATA_W-1:0]   data_mem [DEPTH];
   logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]       count_q, count_d;
   logic                full_q, empty_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                push, pop, need_mem;
   logic                fwd_hit;
   logic [DATA_W-1:0]   fwd_data;

   assign push     = cpu_wr_en && !full_q;
   assign pop      = (state_q == DRAIN) && mem_ready;
   assign need_mem = cpu_rd_en && !fwd_hit;

   assign head_d  = head_q + PW'(pop);
   assign tail_d  = tail_q + PW'(push);
   assign count_d = count_q + CW'(push) - CW'(pop);

`ifdef SRAM_STORE_FWD_EN
   logic [PW-1:0] fwd_idx;

   // Walk oldest to youngest so the last match is the most recent store.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = head_q;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = head_q + PW'(k);
         if ((CW'(k) < count_q) && (addr_mem[fwd_idx] == cpu_addr)) begin
            fwd_hit  = cpu_rd_en;
            fwd_data = data_mem[fwd_idx];
         end
      end
   end
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif

   // NOTE: entry storage has no reset; validity is carried entirely by count_q.
   always_ff @(posedge clock) begin
      if (push) begin
         addr_mem[tail_q] <= cpu_addr;
         data_mem[tail_q] <= cpu_wdata;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Drain FSM; the IDLE pass between accesses gives the controller its gap cycle.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (need_mem && empty_q)
                  state_q <= READ;
               else if (!empty_q)
                  state_q <= DRAIN;
            end
            DRAIN: begin
               if (mem_ready)
                  state_q <= IDLE;
            end
            READ: begin
               if (mem_ready) begin
                  rdata_q <= mem_rdata;
                  state_q <= RDONE;
               end
            end
            RDONE:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      cpu_ready = 1'b1;
      if (cpu_wr_en)
         cpu_ready = !full_q;
      else if (cpu_rd_en)
         cpu_ready = fwd_hit || (state_q == RDONE);
   end

   assign mem_wr_en = (state_q == DRAIN);
   assign mem_rd_en = (state_q == READ);
   assign mem_addr  = (state_q == DRAIN) ? addr_mem[head_q] :
                      (state_q == READ)  ? cpu_addr : '0;
   assign mem_wdata = (state_q == DRAIN) ? data_mem[head_q] : '0;
   assign cpu_rdata = fwd_hit ? fwd_data : rdata_q;

   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: tb/tb_sram_store_buffer.sv
// Directed bench for sram_store_buffer with a latency-programmable SRAM controller model.
// Build with SRAM_STORE_FWD_EN defined to exercise the forwarding expectations.
module tb_sram_store_buffer;

   logic        clock = 1'b0;
   logic        rst;
   logic        cpu_rd_en, cpu_wr_en;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_ready;
   logic        mem_rd_en, mem_wr_en;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic        full, empty;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;
   int lat;
   int req_cycles;
   logic [31:0] sram [logic [31:0]];
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];

   sram_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .rst(rst),
      .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .full(full), .empty(empty), .count(count)
   );

   always #5 clock = ~clock;

   // One clock: record a completing write, cross the edge, update the controller model.
   task automatic step();
      if ((mem_wr_en === 1'b1) && (mem_ready === 1'b1)) begin
         sram[mem_addr] = mem_wdata;
         log_addr.push_back(mem_addr);
         log_data.push_back(mem_wdata);
      end
      @(posedge clock);
      #1;
      if ((mem_rd_en === 1'b1) || (mem_wr_en === 1'b1)) req_cycles++;
      else req_cycles = 0;
      mem_ready = (req_cycles > lat);
      mem_rdata = sram.exists(mem_addr) ? sram[mem_addr] : 32'h0;
   endtask

   task automatic wait_empty(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (empty === 1'b1 && mem_wr_en === 1'b0 && mem_rd_en === 1'b0) begin
            ok = 1'b1;
            break;
         end
         step(); #1;
      end
      total++; if (!ok) begin bad++; $display("FAIL %s drain timeout count=%0d", name, count); end
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0; lat = 0; req_cycles = 0;
      #12;
      total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cpu_ready); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
      total++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin bad++; $display("FAIL rst_req got=%b exp=00", {mem_rd_en, mem_wr_en}); end
      total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
      total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", cpu_rdata); end
      rst = 1'b0;
      step(); #1;
   endtask

   task automatic test_store_drain();
      int n = 0;
      bit seen = 1'b0;
      lat = 3; log_addr.delete(); log_data.delete();
      cpu_wr_en = 1'b1; cpu_addr = 32'h400; cpu_wdata = 32'hDEADBEEF; #1;
      total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL store_ready got=%b exp=1", cpu_ready); end
      step(); cpu_wr_en = 1'b0; #1;
      total++; if (count !== 3'd1) begin bad++; $display("FAIL store_count got=%0d exp=1", count); end
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL store_not_empty got=%b exp=0", empty); end
      for (int i = 0; i < 20; i++) begin
         step(); #1;
         if (mem_wr_en === 1'b1) begin
            seen = 1'b1; n++;
            total++; if (mem_addr !== 32'h400 || mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_bus got=%h/%h exp=400/deadbeef", mem_addr, mem_wdata); end
         end else if (seen) break;
      end
      total++; if (n != 4) begin bad++; $display("FAIL store_wr_cycles got=%0d exp=4", n); end
      total++; if (empty !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL store_after_empty got=%b/%0d exp=1/0", empty, count); end
      total++; if (log_addr.size() != 1) begin bad++; $display("FAIL store_writes got=%0d exp=1", log_addr.size()); end
   endtask

   task automatic test_back_to_back();
      lat = 1000; log_addr.delete(); log_data.delete();
      for (int i = 0; i < 4; i++) begin
         cpu_wr_en = 1'b1; cpu_addr = 32'h600 + 32'(4 * i); cpu_wdata = 32'hA0 + 32'(i); #1;
         total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, cpu_ready); end
         step();
      end
      cpu_addr = 32'h610; cpu_wdata = 32'hA4; #1;
      total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL b2b_full got=%b/%0d exp=1/4", full, count); end
      total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall0 got=%b exp=0", cpu_ready); end
      for (int i = 0; i < 2; i++) begin
         step(); #1;
         total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall[%0d] got=%b exp=0", i, cpu_ready); end
      end
      lat = 0;
      step(); #1;
      total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL b2b_prepop got=%b exp=0", cpu_ready); end
      step(); #1;
      total++; if (count !== 3'd3 || full !== 1'b0) begin bad++; $display("FAIL b2b_pop got=%0d/%b exp=3/0", count, full); end
      total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", cpu_ready); end
      step(); cpu_wr_en = 1'b0; #1;
      total++; if (count !== 3'd4) begin bad++; $display("FAIL b2b_refill got=%0d exp=4", count); end
      lat = 1;
      wait_empty("b2b");
      total++; if (log_addr.size() != 5) begin bad++; $display("FAIL b2b_nwrites got=%0d exp=5", log_addr.size()); end
      for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
         total++;
         if (log_addr[i] !== 32'h600 + 32'(4 * i) || log_data[i] !== 32'hA0 + 32'(i)) begin
            bad++; $display("FAIL b2b_order[%0d] got=%h/%h exp=%h/%h", i, log_addr[i], log_data[i], 32'h600 + 32'(4 * i), 32'hA0 + 32'(i));
         end
      end
   endtask

   task automatic test_wrap();
      lat = 1000; log_addr.delete(); log_data.delete();
      for (int i = 0; i < 3; i++) begin
         cpu_wr_en = 1'b1; cpu_addr = 32'h700 + 32'(4 * i); cpu_wdata = 32'hB0 + 32'(i);
         step();
      end
      cpu_wr_en = 1'b0; #1;
      total++; if (count !== 3'd3 || mem_wr_en !== 1'b1) begin bad++; $display("FAIL wrap_pre got=%0d/%b exp=3/1", count, mem_wr_en); end
      lat = 0;
      step();
      cpu_wr_en = 1'b1; cpu_addr = 32'h70C; cpu_wdata = 32'hB3; #1;
      total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready got=%b exp=1", cpu_ready); end
      step(); cpu_wr_en = 1'b0; #1;
      total++; if (count !== 3'd3 || full !== 1'b0) begin bad++; $display("FAIL wrap_count got=%0d/%b exp=3/0", count, full); end
      lat = 1;
      wait_empty("wrap");
      total++; if (log_addr.size() != 4) begin bad++; $display("FAIL wrap_nwrites got=%0d exp=4", log_addr.size()); end
      for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
         total++;
         if (log_addr[i] !== 32'h700 + 32'(4 * i) || log_data[i] !== 32'hB0 + 32'(i)) begin
            bad++; $display("FAIL wrap_order[%0d] got=%h/%h exp=%h/%h", i, log_addr[i], log_data[i], 32'h700 + 32'(4 * i), 32'hB0 + 32'(i));
         end
      end
   endtask

   task automatic test_forward();
      lat = 1000; log_addr.delete(); log_data.delete();
      cpu_wr_en = 1'b1; cpu_addr = 32'h404; cpu_wdata = 32'h11; step();
      cpu_wdata = 32'h22; step();
      cpu_wr_en = 1'b0; cpu_rd_en = 1'b1; cpu_addr = 32'h404; #1;
`ifdef SRAM_STORE_FWD_EN
      total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL fwd_ready got=%b exp=1", cpu_ready); end
      total++; if (cpu_rdata !== 32'h22) begin bad++; $display("FAIL fwd_data got=%h exp=22", cpu_rdata); end
      total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL fwd_no_read got=%b exp=0", mem_rd_en); end
      step(); cpu_rd_en = 1'b0; #1;
      lat = 1;
      wait_empty("fwd");
`else
      begin
         bit done = 1'b0, rd_seen = 1'b0, early = 1'b0;
         total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL ld_wait got=%b exp=0", cpu_ready); end
         lat = 1;
         for (int i = 0; i < 100; i++) begin
            step(); #1;
            if (mem_rd_en === 1'b1) begin
               rd_seen = 1'b1;
               if (count !== 3'd0 || log_addr.size() != 2) early = 1'b1;
            end
            if (cpu_ready === 1'b1) begin done = 1'b1; break; end
         end
         total++; if (!done || !rd_seen) begin bad++; $display("FAIL ld_complete got=%b/%b exp=1/1", done, rd_seen); end
         total++; if (early) begin bad++; $display("FAIL ld_order got=read_before_drain exp=drained"); end
         total++; if (cpu_rdata !== 32'h22) begin bad++; $display("FAIL ld_data got=%h exp=22", cpu_rdata); end
         step(); cpu_rd_en = 1'b0; #1;
      end
`endif
      total++; if (log_addr.size() != 2) begin bad++; $display("FAIL same_addr_nwrites got=%0d exp=2", log_addr.size()); end
      else begin
         total++; if (log_data[0] !== 32'h11 || log_data[1] !== 32'h22) begin bad++; $display("FAIL same_addr_order got=%h,%h exp=11,22", log_data[0], log_data[1]); end
      end
   endtask

   task automatic test_load_miss();
      int rd_n = 0, got = 0, both = 0;
      lat = 5;
      cpu_rd_en = 1'b1; cpu_addr = 32'h500; #1;
      total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL miss_wait got=%b exp=0", cpu_ready); end
      for (int k = 1; k <= 30; k++) begin
         step(); #1;
         if (mem_rd_en === 1'b1) begin
            rd_n++;
            if (mem_wr_en !== 1'b0 || mem_addr !== 32'h500) both++;
         end
         if (cpu_ready === 1'b1) begin got = k; break; end
      end
      total++; if (rd_n != 6) begin bad++; $display("FAIL miss_rd_cycles got=%0d exp=6", rd_n); end
      total++; if (got != 7) begin bad++; $display("FAIL miss_latency got=%0d exp=7", got); end
      total++; if (both != 0) begin bad++; $display("FAIL miss_bus got=%0d exp=0", both); end
      total++; if (cpu_rdata !== 32'hCAFE0500) begin bad++; $display("FAIL miss_data got=%h exp=cafe0500", cpu_rdata); end
      step(); cpu_rd_en = 1'b0; #1;
   endtask

   task automatic test_reset_mid();
      lat = 1000;
      cpu_wr_en = 1'b1; cpu_addr = 32'h800; cpu_wdata = 32'h1; step();
      cpu_addr = 32'h804; cpu_wdata = 32'h2; step();
      cpu_wr_en = 1'b0; step(); #1;
      total++; if (mem_wr_en !== 1'b1 || count !== 3'd2) begin bad++; $display("FAIL mid_pre got=%b/%0d exp=1/2", mem_wr_en, count); end
      rst = 1'b1; #1;
      total++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin bad++; $display("FAIL mid_req got=%b exp=00", {mem_rd_en, mem_wr_en}); end
      total++; if (cpu_ready !== 1'b1 || empty !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL mid_status got=%b/%b/%0d exp=1/1/0", cpu_ready, empty, count); end
      step(); rst = 1'b0; step(); step(); #1;
      total++; if (mem_wr_en !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL mid_discard got=%b/%b exp=0/1", mem_wr_en, empty); end
      cpu_rd_en = 1'b1; cpu_addr = 32'h500; step(); step(); #1;
      total++; if (mem_rd_en !== 1'b1) begin bad++; $display("FAIL rdmid_pre got=%b exp=1", mem_rd_en); end
      rst = 1'b1; #1;
      total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL rdmid_req got=%b exp=0", mem_rd_en); end
      cpu_rd_en = 1'b0; step(); rst = 1'b0; step(); #1;
      total++; if (cpu_ready !== 1'b1 || mem_rd_en !== 1'b0) begin bad++; $display("FAIL rdmid_idle got=%b/%b exp=1/0", cpu_ready, mem_rd_en); end
   endtask

   initial begin
      sram[32'h500] = 32'hCAFE0500;
      test_reset();
      test_store_drain();
      test_back_to_back();
      test_wrap();
      test_forward();
      test_load_miss();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
